// File: rtl/char_window_encoder.sv
// char_window_encoder: maps ASCII letters/space to one-hot classes and keeps a
// sliding window of the last SEQ_LENGTH letters, offered downstream when full.
module char_window_encoder #(
   parameter int SEQ_LENGTH = 4,
   parameter int ENC = 27,
   parameter int FW = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [7:0]                in_char,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      flush,
   output logic [ENC*SEQ_LENGTH-1:0] word,
   output logic                      word_valid,
   input  logic                      word_ready,
   output logic [FW-1:0]             fill,
   output logic                      drop,
   output logic [15:0]               word_count
);
   localparam int W = ENC*SEQ_LENGTH;
   logic lower, upper, mappable, accept, consume, shift;
   logic [4:0] cls;
   logic [ENC-1:0] onehot;
   logic [FW-1:0] fill_next;
   assign lower = in_char >= 8'h61 && in_char <= 8'h7a;
   assign upper = in_char >= 8'h41 && in_char <= 8'h5a;
   assign mappable = lower || upper || in_char == 8'h20;
   assign cls = lower ? 5'(in_char - 8'h60) : upper ? 5'(in_char - 8'h40) : 5'd0;
   assign onehot = ENC'(1) << cls;
   assign in_ready = !flush && !(word_valid && !word_ready);
   assign accept = in_valid && in_ready;
   assign consume = word_valid && word_ready;
   assign shift = accept && mappable;
   assign fill_next = (fill == FW'(SEQ_LENGTH)) ? fill : fill + 1'b1;
   // newest letter enters the top slot; the oldest falls off slot 0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word <= '0;
         word_valid <= 1'b0;
         fill <= '0;
         drop <= 1'b0;
         word_count <= '0;
      end else begin
         if (consume) word_count <= word_count + 16'd1;
         if (flush) begin
            word <= '0;
            fill <= '0;
            word_valid <= 1'b0;
            drop <= 1'b0;
         end else begin
            drop <= accept && !mappable;
            if (shift) begin
               word <= (word >> ENC) | (W'(onehot) << (W - ENC));
               fill <= fill_next;
               word_valid <= fill_next == FW'(SEQ_LENGTH);
            end else if (consume) begin
               word_valid <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_char_window_encoder.sv
// tb_char_window_encoder: random and directed stimulus against a queue-based
// model of the last SEQ letters; a second instance carries the count wrap.
module tb_char_window_encoder;
   localparam int SEQ = 4;
   localparam int ENC = 27;
   localparam int W = SEQ*ENC;
   logic clk = 0, rst = 1, rst2 = 1;
   logic [7:0] in_char = 0;
   logic in_valid = 0, flush = 0, word_ready = 0;
   logic in_ready, word_valid, drop;
   logic [W-1:0] word;
   logic [2:0] fill;
   logic [15:0] word_count;
   logic in_ready2, word_valid2, drop2;
   logic [W-1:0] word2;
   logic [2:0] fill2;
   logic [15:0] word_count2;
   int n_cmp = 0, n_bad = 0;
   int hist[$];
   bit m_valid, m_drop, m_rdy, m_acc, m_cons;
   logic [15:0] m_count;
   int m_c;

   always #5 clk = ~clk;

   char_window_encoder dut (.clk(clk), .rst(rst), .in_char(in_char), .in_valid(in_valid),
      .in_ready(in_ready), .flush(flush), .word(word), .word_valid(word_valid),
      .word_ready(word_ready), .fill(fill), .drop(drop), .word_count(word_count));
   char_window_encoder u_wrap (.clk(clk), .rst(rst2), .in_char(in_char), .in_valid(in_valid),
      .in_ready(in_ready2), .flush(flush), .word(word2), .word_valid(word_valid2),
      .word_ready(word_ready), .fill(fill2), .drop(drop2), .word_count(word_count2));

   function automatic int cls_of(input logic [7:0] c);
      if (c == 8'h20) return 0;
      if (c >= 8'h61 && c <= 8'h7a) return int'(c) - 'h60;
      if (c >= 8'h41 && c <= 8'h5a) return int'(c) - 'h40;
      return -1;
   endfunction

   // right-aligned history: the newest letter sits in slot SEQ-1
   function automatic logic [W-1:0] exp_word();
      logic [W-1:0] w = '0;
      for (int i = 0; i < hist.size(); i++) w[(SEQ - hist.size() + i)*ENC + hist[i]] = 1'b1;
      return w;
   endfunction

   function automatic logic [W-1:0] w4(input int a, input int b, input int c, input int d);
      logic [W-1:0] w = '0;
      if (a >= 0) w[0*ENC + a] = 1'b1;
      if (b >= 0) w[1*ENC + b] = 1'b1;
      if (c >= 0) w[2*ENC + c] = 1'b1;
      if (d >= 0) w[3*ENC + d] = 1'b1;
      return w;
   endfunction

   function automatic logic [7:0] rand_char();
      int r = $urandom_range(0, 9);
      if (r < 5) return 8'(8'h61 + $urandom_range(0, 25));
      if (r < 7) return 8'(8'h41 + $urandom_range(0, 25));
      if (r == 7) return 8'h20;
      return 8'($urandom_range(0, 255));
   endfunction

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic put(input logic [7:0] c);
      in_char = c;
      in_valid = 1;
      @(posedge clk);
      #1;
      in_valid = 0;
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         hist.delete();
         m_valid = 0;
         m_drop = 0;
         m_count = 0;
      end else begin
         m_rdy = !flush && !(m_valid && !word_ready);
         m_acc = in_valid && m_rdy;
         m_cons = m_valid && word_ready;
         m_c = cls_of(in_char);
         if (m_cons) m_count = m_count + 16'd1;
         if (flush) begin
            hist.delete();
            m_valid = 0;
            m_drop = 0;
         end else begin
            m_drop = m_acc && m_c < 0;
            if (m_acc && m_c >= 0) begin
               hist.push_back(m_c);
               if (hist.size() > SEQ) void'(hist.pop_front());
               m_valid = hist.size() == SEQ;
            end else if (m_cons) m_valid = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("m_word", word, exp_word());
         chk("m_valid", word_valid, m_valid);
         chk("m_fill", fill, hist.size());
         chk("m_drop", drop, m_drop);
         chk("m_count", word_count, m_count);
         chk("m_in_ready", in_ready, !flush && !(m_valid && !word_ready));
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
      rst2 = 0;
      chk("rst_word", word, 0);
      chk("rst_valid", word_valid, 0);
      chk("rst_fill", fill, 0);
      chk("rst_drop", drop, 0);
      chk("rst_count", word_count, 0);
      chk("rst_in_ready", in_ready, 1);
      repeat (3000) begin
         in_valid = $urandom_range(0, 3) != 0;
         word_ready = $urandom_range(0, 2) != 0;
         flush = $urandom_range(0, 19) == 0;
         in_char = rand_char();
         @(posedge clk);
         #1;
      end
      in_valid = 0;
      flush = 0;
      rst = 1;
      rst2 = 1;
      @(posedge clk);
      #1;
      rst = 0;
      rst2 = 0;
      word_ready = 1;
      put("a"); put("b"); put("c");
      chk("fill_valid", word_valid, 0);
      chk("fill_3", fill, 3);
      put("d");
      chk("fill_full_valid", word_valid, 1);
      chk("fill_abcd", word, w4(1, 2, 3, 4));
      word_ready = 0;
      in_valid = 1;
      in_char = "e";
      repeat (5) begin
         @(posedge clk);
         #1;
         chk("bp_in_ready", in_ready, 0);
         chk("bp_word", word, w4(1, 2, 3, 4));
      end
      word_ready = 1;
      #1;
      chk("bp_ready_same_cycle", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 0;
      chk("bp_bcde", word, w4(2, 3, 4, 5));
      chk("bp_valid", word_valid, 1);
      chk("bp_count", word_count, 1);
      put("A"); put(" "); put("Z"); put("b");
      chk("fold_word", word, w4(1, 0, 26, 2));
      put("a"); put("b"); put("c"); put("d");
      put("7");
      chk("drop_pulse", drop, 1);
      chk("drop_word", word, w4(1, 2, 3, 4));
      chk("drop_fill", fill, 4);
      chk("drop_valid", word_valid, 0);
      put("x");
      chk("drop_end", drop, 0);
      chk("drop_bcdx", word, w4(2, 3, 4, 24));
      chk("drop_x_valid", word_valid, 1);
      flush = 1;
      in_valid = 1;
      in_char = "q";
      #1;
      chk("flush_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
      flush = 0;
      in_valid = 0;
      chk("flush_word", word, 0);
      chk("flush_fill", fill, 0);
      chk("flush_valid", word_valid, 0);
      for (int k = 0; k < 70000 && m_count != 16'hFFFF; k++) begin
         in_char = 8'(8'h61 + $urandom_range(0, 25));
         in_valid = 1;
         @(posedge clk);
         #1;
      end
      in_valid = 0;
      word_ready = 0;
      #1;
      chk("pre_rst_count", word_count, 16'hFFFF);
      chk("pre_rst_valid", word_valid, 1);
      chk("wrap_pre_count", word_count2, 16'hFFFF);
      rst = 1;
      #1;
      chk("arst_word", word, 0);
      chk("arst_valid", word_valid, 0);
      chk("arst_fill", fill, 0);
      chk("arst_drop", drop, 0);
      chk("arst_count", word_count, 0);
      rst = 0;
      #1;
      chk("arst_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      word_ready = 1;
      @(posedge clk);
      #1;
      chk("wrap_count", word_count2, 0);
      chk("wrap_valid", word_valid2, 0);
      chk("post_rst_count", word_count, 0);
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/char_window_encoder.md
# char_window_encoder

Front-end stage of the next-word predictor. It accepts ASCII characters one per handshake, maps each to a one-hot class over the 27-symbol alphabet, and keeps a sliding window of the last SEQ_LENGTH characters. It presents that window as the packed one-hot `word` bus consumed by the LSTM forward-pass top. A new window is offered downstream after every accepted letter once the window is full.

## Interface

**Parameters**
- `SEQ_LENGTH`, default 4: window length in characters. Must match the forward-pass sequence length.
- `ENC`, default 27: one-hot width per character. Class 0 is space; classes 1..26 are 'a'..'z'.
- `FW`, default 3: width of `fill`, equal to clog2(SEQ_LENGTH+1).

**Ports**
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `in_char`, input, 8: ASCII character.
- `in_valid`, input, 1: `in_char` is valid.
- `in_ready`, output, 1: block can accept `in_char` this cycle.
- `flush`, input, 1: synchronous clear of the window.
- `word`, output, ENC*SEQ_LENGTH: window. Slot i is `word[i*ENC +: ENC]`; slot 0 is the oldest, slot SEQ_LENGTH-1 the newest.
- `word_valid`, output, 1: `word` holds a full, unconsumed window.
- `word_ready`, input, 1: downstream consumes `word`.
- `fill`, output, FW: number of letters currently in the window, 0..SEQ_LENGTH.
- `drop`, output, 1: one-cycle pulse; the previous accepted character was unmappable and discarded.
- `word_count`, output, 16: number of windows consumed (`word_valid && word_ready` cycles). Wraps modulo 2^16.

## Operation

**Character mapping (combinational on `in_char`)**
- 0x20 maps to class 0.
- 0x61..0x7A maps to class `in_char - 0x60`.
- 0x41..0x5A maps to class `in_char - 0x40` (case fold).
- Every other code is unmappable.

**Accept**
- `accept = in_valid && in_ready`.
- `in_ready = !flush && !(word_valid && !word_ready)`. The block stalls only while a full window is pending and unconsumed.

**Accepted mappable character**
- Slot i takes slot i+1 for i < SEQ_LENGTH-1.
- Slot SEQ_LENGTH-1 takes the one-hot of the class; exactly one bit is set.
- `fill` increments and saturates at SEQ_LENGTH.
- If the post-shift `fill` equals SEQ_LENGTH, `word_valid` is 1 next cycle.

**Accepted unmappable character**
- Window and `fill` are unchanged.
- `drop` = 1 for one cycle.
- `word_valid` follows the consume rule below.

**Consume**
- When `word_valid && word_ready`, `word_count` increments.
- If no mappable character is accepted in the same cycle, `word_valid` goes to 0.
- If one is accepted in the same cycle, the window shifts and `word_valid` stays 1, presenting the new window.

**Stability**
- While `word_valid && !word_ready`, `word` and `word_valid` hold unchanged. This is guaranteed because `in_ready` = 0.

**Flush**
- Has priority over everything else.
- Next cycle: window = 0, `fill` = 0, `word_valid` = 0, `drop` = 0.
- `word_count` is retained.
- The input character is not accepted that cycle.

**Empty slots**
- Slots not yet filled read as all-zero.

## Timing

- **Reset values:** `word` = 0, `word_valid` = 0, `fill` = 0, `drop` = 0, `word_count` = 0. `in_ready` = 1 once `rst` is low and `flush` is low.
- **Reset mid-operation:** clears all state immediately (asynchronous), including a pending window. No window is emitted from pre-reset characters.
- **Latency:** 1 cycle. A character accepted at edge N appears in slot SEQ_LENGTH-1 after edge N, and `word_valid` updates at the same edge.
- **Throughput:** one window per cycle while `word_ready` = 1 and `in_valid` = 1 with mappable characters.
- **`fill` boundary:** at SEQ_LENGTH the oldest slot is discarded on each accepted letter; there is no overflow.
- **`word_count`:** 0xFFFF + 1 wraps to 0x0000.
- **Outputs:** `word`, `word_valid`, `fill`, `drop` and `word_count` are registered. `in_ready` is combinational from `word_valid`, `word_ready` and `flush`.

## Test plan

1. **Fill:**
   - Stimulus: reset, then send "abc" with `word_ready` = 1.
   - Required: `word_valid` stays 0 and `fill` = 3.
   - Stimulus: then send "d".
   - Required: next cycle `word_valid` = 1 with slots 0..3 equal to one-hot bit 1, 2, 3, 4.
2. **Backpressure:**
   - Stimulus: full window "abcd", `word_ready` = 0, `in_valid` = 1 with 'e' held for 5 cycles.
   - Required: `in_ready` = 0 and `word` unchanged.
   - Stimulus: raise `word_ready`.
   - Required: 'e' is accepted in the same cycle; next window is "bcde" and `word_count` = 1.
3. **Case fold and space:**
   - Stimulus: send "A Zb".
   - Required: slots hold classes 1, 0, 26, 2.
4. **Drop:**
   - Stimulus: window "abcd" consumed, then send '7'.
   - Required: `drop` pulses for 1 cycle, `word` still reads "abcd", `fill` = 4, `word_valid` = 0.
   - Stimulus: then send 'x'.
   - Required: window "bcdx" and `word_valid` = 1.
5. **Flush versus input:**
   - Stimulus: assert `flush` with `in_valid` = 1 ('q') while `word_valid` = 1.
   - Required: next cycle `word` = 0, `fill` = 0, `word_valid` = 0, and 'q' is not accepted.
6. **Asynchronous reset mid-stream:**
   - Stimulus: pulse `rst` between clock edges with `word_valid` = 1 and `word_count` = 0xFFFF.
   - Required: all outputs go to 0 before the next edge.
   - Separately: with `word_count` = 0xFFFF and no reset, one consume wraps it to 0.
